// File: rtl/regfile_mp_if.sv
// Bus bundle between the cpu datapath (master) and the multi-port register file (slave).
// Carries the read ports, the byte-enabled write port, branch/link controls and the PC.
interface regfile_mp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned NREAD  = 2
);
   logic [NREAD*ADDR_W-1:0] raddr;
   logic [NREAD*DATA_W-1:0] rdata;
   logic                    we;
   logic [ADDR_W-1:0]       wa;
   logic [DATA_W-1:0]       wd;
   logic [DATA_W/8-1:0]     wbe;
   logic                    ib;
   logic [DATA_W-1:0]       bv;
   logic                    bl;
   logic                    stall;
   logic [DATA_W-1:0]       iaddrout;

   modport master (
      output raddr, we, wa, wd, wbe, ib, bv, bl, stall,
      input  rdata, iaddrout
   );

   modport slave (
      input  raddr, we, wa, wd, wbe, ib, bv, bl, stall,
      output rdata, iaddrout
   );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised register file: NREAD registered read ports, one byte-enabled write port,
// PC at NREGS-1 and link register at NREGS-2. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_mp #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       ADDR_W   = 4,
   parameter int unsigned       NREAD    = 2,
   parameter int unsigned       PC_INC   = 4,
   parameter logic [DATA_W-1:0] PC_RESET = '0
) (
   input logic         clk,
   input logic         reset,
   regfile_mp_if.slave bus
);
   localparam int unsigned       NREGS   = 1 << ADDR_W;
   localparam int unsigned       NBYTES  = DATA_W / 8;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(NREGS - 1);
   localparam logic [ADDR_W-1:0] LR_ADDR = ADDR_W'(NREGS - 2);
   localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);

   // The PC lives in its own register, so the array only holds the GPRs (0..NREGS-2).
   logic [DATA_W-1:0]       regs_q [NREGS-1];
   logic [DATA_W-1:0]       regs_d [NREGS-1];
   logic [DATA_W-1:0]       pc_q, pc_d;
   logic [DATA_W-1:0]       link_val;
   logic [NREAD*DATA_W-1:0] rdata_q, rdata_d;
   logic                    pc_write;

   assign link_val = pc_q + PC_STEP;
   assign pc_write = bus.we && (bus.wa == PC_ADDR);

   always_comb begin
      regs_d = regs_q;
      if (bus.we && (bus.wa != PC_ADDR)) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (bus.wbe[b]) begin
               regs_d[bus.wa][8*b +: 8] = bus.wd[8*b +: 8];
            end
         end
      end
      // Link is applied last so it overrides a same-edge port write to LR.
      if (bus.ib && bus.bl) begin
         regs_d[LR_ADDR] = link_val;
      end
   end

   always_comb begin
      pc_d = pc_q;
      if (bus.ib) begin
         pc_d = bus.bv;
      end else if (pc_write) begin
         pc_d = bus.wd;
      end else if (!bus.stall) begin
         pc_d = link_val;
      end
   end

   for (genvar k = 0; k < NREAD; k++) begin : g_read
      logic [ADDR_W-1:0] ra;
      assign ra = bus.raddr[k*ADDR_W +: ADDR_W];
      // PC reads always return the current PC, never the next one.
`ifdef REGFILE_BYPASS_EN
      assign rdata_d[k*DATA_W +: DATA_W] = (ra == PC_ADDR) ? pc_q : regs_d[ra];
`else
      assign rdata_d[k*DATA_W +: DATA_W] = (ra == PC_ADDR) ? pc_q : regs_q[ra];
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q  <= '{default: '0};
         pc_q    <= PC_RESET;
         rdata_q <= '0;
      end else begin
         regs_q  <= regs_d;
         pc_q    <= pc_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.rdata    = rdata_q;
   assign bus.iaddrout = pc_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by randomized traffic
// compared against an array-based reference model of the register file and PC.
`timescale 1ns/1ps
module tb_regfile_mp;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned NREAD  = 2;
   localparam int unsigned PC_INC = 4;

   logic        clk = 1'b0;
   logic        reset;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   logic [31:0] m_reg [16];
   logic [31:0] m_pc;
   logic [31:0] saved_pc;

   regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus ();

   regfile_mp #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NREAD   (NREAD),
      .PC_INC  (PC_INC),
      .PC_RESET(32'h0)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_pc = '0;
   endtask

   task automatic idle();
      bus.raddr = '0;
      bus.we    = 1'b0;
      bus.wa    = '0;
      bus.wd    = '0;
      bus.wbe   = '0;
      bus.ib    = 1'b0;
      bus.bv    = '0;
      bus.bl    = 1'b0;
      bus.stall = 1'b0;
   endtask

   // Predict one clock edge from the current inputs, clock it, compare, then commit.
   task automatic step();
      logic [31:0] nreg [16];
      logic [31:0] npc;
      logic [31:0] mask;
      logic [31:0] exp_rd [NREAD];
      logic [3:0]  a;
      for (int i = 0; i < 16; i++) nreg[i] = m_reg[i];
      for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{bus.wbe[b]}};
      if (bus.we && bus.wa != 4'd15) nreg[bus.wa] = (m_reg[bus.wa] & ~mask) | (bus.wd & mask);
      if (bus.ib && bus.bl) nreg[14] = m_pc + PC_INC;
      if (bus.ib) npc = bus.bv;
      else if (bus.we && bus.wa == 4'd15) npc = bus.wd;
      else if (!bus.stall) npc = m_pc + PC_INC;
      else npc = m_pc;
      for (int k = 0; k < NREAD; k++) begin
         a = bus.raddr[k*4 +: 4];
`ifdef REGFILE_BYPASS_EN
         exp_rd[k] = (a == 4'd15) ? m_pc : nreg[a];
`else
         exp_rd[k] = (a == 4'd15) ? m_pc : m_reg[a];
`endif
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NREAD; k++) begin
         check_eq($sformatf("rdata%0d", k), bus.rdata[k*32 +: 32], exp_rd[k]);
      end
      check_eq("iaddrout", bus.iaddrout, npc);
      for (int i = 0; i < 16; i++) m_reg[i] = nreg[i];
      m_pc = npc;
   endtask

   // Called just after a step; pulses reset well away from any clock edge.
   task automatic mid_reset();
      #2 reset = 1'b1;
      #1;
      check_eq("rst_pc", bus.iaddrout, 32'h0);
      for (int k = 0; k < NREAD; k++) begin
         check_eq($sformatf("rst_rdata%0d", k), bus.rdata[k*32 +: 32], 32'h0);
      end
      model_reset();
      #2 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      model_reset();
      #12;
      check_eq("reset_pc", bus.iaddrout, 32'h0);
      check_eq("reset_rd0", bus.rdata[31:0], 32'h0);
      check_eq("reset_rd1", bus.rdata[63:32], 32'h0);
      reset = 1'b0;

      // Three free-running cycles.
      for (int i = 0; i < 3; i++) step();
      check_eq("pc_free3", bus.iaddrout, 32'd12);

      // Byte-enabled merge into r3.
      idle(); bus.we = 1'b1; bus.wa = 4'd3; bus.wd = 32'hDEADBEEF; bus.wbe = 4'hF;
      step();
      idle(); bus.we = 1'b1; bus.wa = 4'd3; bus.wd = 32'h000000AA; bus.wbe = 4'b0001;
      step();
      idle(); bus.raddr = {4'd3, 4'd3};
      step();
      check_eq("r3_merge", bus.rdata[31:0], 32'hDEADBEAA);

      // Same-edge write and read of r5.
      idle(); bus.we = 1'b1; bus.wa = 4'd5; bus.wd = 32'h1234; bus.wbe = 4'hF;
      bus.raddr = {4'd0, 4'd5};
      step();
`ifdef REGFILE_BYPASS_EN
      check_eq("r5_same_edge", bus.rdata[31:0], 32'h1234);
`else
      check_eq("r5_same_edge", bus.rdata[31:0], 32'h0);
`endif

      // Branch-and-link beats a port write to LR.
      idle(); bus.we = 1'b1; bus.wa = 4'd15; bus.wd = 32'h100; bus.wbe = 4'h0;
      step();
      check_eq("pc_write", bus.iaddrout, 32'h100);
      idle(); bus.ib = 1'b1; bus.bl = 1'b1; bus.bv = 32'h400;
      bus.we = 1'b1; bus.wa = 4'd14; bus.wd = 32'h55; bus.wbe = 4'hF;
      step();
      check_eq("bl_pc", bus.iaddrout, 32'h400);
      idle(); bus.stall = 1'b1; bus.raddr = {4'd15, 4'd14};
      step();
      check_eq("bl_lr", bus.rdata[31:0], 32'h104);
      check_eq("pc_read", bus.rdata[63:32], 32'h400);

      // Stall holds, but a branch still applies.
      saved_pc = m_pc;
      for (int i = 0; i < 4; i++) begin
         idle(); bus.stall = 1'b1;
         step();
         check_eq("stall_hold", bus.iaddrout, saved_pc);
      end
      idle(); bus.stall = 1'b1; bus.ib = 1'b1; bus.bv = 32'h80;
      step();
      check_eq("stall_branch", bus.iaddrout, 32'h80);

      // PC wrap, then reset mid-operation.
      idle(); bus.stall = 1'b1; bus.we = 1'b1; bus.wa = 4'd15; bus.wd = 32'hFFFFFFFC;
      step();
      idle();
      step();
      check_eq("pc_wrap", bus.iaddrout, 32'h0);
      mid_reset();

      for (int i = 0; i < 500; i++) begin
         idle();
         bus.we    = 1'($urandom_range(0, 1));
         bus.wa    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom);
         bus.wd    = $urandom;
         bus.wbe   = 4'($urandom);
         bus.ib    = ($urandom_range(0, 7) == 0);
         bus.bl    = 1'($urandom_range(0, 1));
         bus.bv    = $urandom;
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.raddr = 8'($urandom);
         if ($urandom_range(0, 2) == 0) bus.raddr[3:0] = bus.wa;
         step();
         if ($urandom_range(0, 63) == 0) mid_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
